// File: rtl/pattern_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding,
// legal pattern-length range and a range-check helper.
package pattern_det_pkg;

  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 16;

  // IDLE: no pattern loaded; FILL: fewer than N-1 valid bits held;
  // HUNT: at least N-1 valid bits held, every accepted bit is a candidate match.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HUNT = 2'd2
  } state_t;

  function automatic bit n_in_range(input int unsigned n);
    return (n >= N_MIN) && (n <= N_MAX);
  endfunction

endpackage

// File: rtl/sat_match_counter.sv
// Saturating match counter with synchronous clear.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count one match this cycle
//   clr        : synchronous clear; clr with inc loads 1
//   count      : registered saturating count
module sat_match_counter
  import pattern_det_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins over accumulation but still records a same-cycle match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pattern_seq_detector.sv
// Serial bit-pattern detector with loadable N-bit pattern, optional
// overlapping matches and a saturating match counter.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   load          : capture pattern_in and restart the search (priority)
//   pattern_in    : pattern, bit N-1 is received first
//   stream_in     : serial data, sampled when stream_valid is high
//   stream_valid  : qualifies stream_in
//   count_clr     : synchronous clear of match_count
//   pattern_found : one-cycle pulse the cycle after the completing bit
//   match_count   : saturating match count
//   busy          : a pattern is loaded (state is not IDLE)
module pattern_seq_detector
  import pattern_det_pkg::*;
#(
  parameter int unsigned N       = 5,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned OVERLAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [N-1:0]     pattern_in,
  input  logic             stream_in,
  input  logic             stream_valid,
  input  logic             count_clr,
  output logic             pattern_found,
  output logic [CNT_W-1:0] match_count,
  output logic             busy
);

  localparam int unsigned FILL_W = $clog2(N + 1);
  localparam bit          OVL    = (OVERLAP != 0);

  if (!n_in_range(N)) begin : g_bad_n
    $error("pattern_seq_detector: N out of range");
  end

  state_t            state;
  logic [N-1:0]      pat_reg;
  logic [N-1:0]      history;
  logic [FILL_W-1:0] fill;

  logic              accept;
  logic              match;
  logic [N-1:0]      shifted;
  logic [FILL_W-1:0] fill_inc;

  // A bit is taken only with a pattern loaded and no concurrent load.
  assign accept   = stream_valid && !load && (state != ST_IDLE);
  assign shifted  = {history[N-2:0], stream_in};
  assign match    = accept && (state == ST_HUNT) && (shifted == pat_reg);
  assign fill_inc = (fill == FILL_W'(N)) ? fill : fill + FILL_W'(1);

  // Detector FSM, shift history and registered match pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      pat_reg       <= '0;
      history       <= '0;
      fill          <= '0;
      pattern_found <= 1'b0;
      busy          <= 1'b0;
    end else begin
      pattern_found <= match;
      if (load) begin
        pat_reg <= pattern_in;
        history <= '0;
        fill    <= '0;
        state   <= ST_FILL;
        busy    <= 1'b1;
      end else if (accept) begin
        history <= shifted;
        if (match && !OVL) begin
          // Non-overlapping: the next match needs N fresh bits.
          fill  <= '0;
          state <= ST_FILL;
        end else begin
          fill <= fill_inc;
          if ((state == ST_FILL) && (fill_inc >= FILL_W'(N - 1))) begin
            state <= ST_HUNT;
          end
        end
      end
    end
  end

  sat_match_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (count_clr),
    .count (match_count)
  );

endmodule
